wb_scoreboard: RTL

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard_if.sv | 57 +++++
 rtl/wb_scoreboard.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard_if.sv
// Bundle between a test harness and wb_scoreboard: run control, expected table, writeback monitor.
// WB_SCOREBOARD_HALT_EN adds a halt input that ends the RUN window early.
interface wb_scoreboard_if #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NCHECK     = 8,
  parameter int MAX_CYCLES = 20
);
  localparam int IW = (NCHECK > 1) ? $clog2(NCHECK) : 1;
  localparam int FW = $clog2(NCHECK + 1);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic              start;
  logic              exp_we;
  logic [IW-1:0]     exp_idx;
  logic [REG_AW-1:0] exp_reg;
  logic [DATA_W-1:0] exp_val;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              pass;
  logic [FW-1:0]     fail_cnt;
  logic [IW-1:0]     first_fail_idx;
  logic [CW-1:0]     cycle_cnt;
`ifdef WB_SCOREBOARD_HALT_EN
  logic              halt;

  modport master (
    output start, exp_we, exp_idx, exp_reg, exp_val,
    output wb_en, wb_reg, wb_data, halt,
    input  core_reset, busy, done, pass,
    input  fail_cnt, first_fail_idx, cycle_cnt
  );
  modport slave (
    input  start, exp_we, exp_idx, exp_reg, exp_val,
    input  wb_en, wb_reg, wb_data, halt,
    output core_reset, busy, done, pass,
    output fail_cnt, first_fail_idx, cycle_cnt
  );
`else
  modport master (
    output start, exp_we, exp_idx, exp_reg, exp_val,
    output wb_en, wb_reg, wb_data,
    input  core_reset, busy, done, pass,
    input  fail_cnt, first_fail_idx, cycle_cnt
  );
  modport slave (
    input  start, exp_we, exp_idx, exp_reg, exp_val,
    input  wb_en, wb_reg, wb_data,
    output core_reset, busy, done, pass,
    output fail_cnt, first_fail_idx, cycle_cnt
  );
`endif
endinterface

// File: rtl/wb_scoreboard.sv
// Runs a core for a fixed window, shadows its register writebacks, then checks an expected table.
// Optional feature: define WB_SCOREBOARD_HALT_EN for an early-halt input.
module wb_scoreboard #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int NCHECK       = 8,
  parameter int MAX_CYCLES   = 20,
  parameter int RESET_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  wb_scoreboard_if.slave bus
);
  localparam int IW   = (NCHECK > 1) ? $clog2(NCHECK) : 1;
  localparam int FW   = $clog2(NCHECK + 1);
  localparam int CW   = $clog2(MAX_CYCLES + 1);
  localparam int CMAX = (RESET_CYCLES > NCHECK) ? RESET_CYCLES : NCHECK;
  localparam int CNW  = $clog2(CMAX + 1);
  localparam int NREG = 1 << REG_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [IW-1:0]     ffi_q, ffi_d;
  logic [DATA_W-1:0] shadow_q [NREG];
  logic [DATA_W-1:0] shadow_d [NREG];
  logic [REG_AW-1:0] exp_reg_q [NCHECK];
  logic [REG_AW-1:0] exp_reg_d [NCHECK];
  logic [DATA_W-1:0] exp_val_q [NCHECK];
  logic [DATA_W-1:0] exp_val_d [NCHECK];
  logic [NCHECK-1:0] vld_q, vld_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              halt_w;
  logic [IW-1:0]     ci;

`ifdef WB_SCOREBOARD_HALT_EN
  assign halt_w = bus.halt;
`else
  assign halt_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    fcnt_d    = fcnt_q;
    ffi_d     = ffi_q;
    shadow_d  = shadow_q;
    exp_reg_d = exp_reg_q;
    exp_val_d = exp_val_q;
    vld_d     = vld_q;
    ci        = cnt_q[IW-1:0];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.exp_we) begin
          exp_reg_d[bus.exp_idx] = bus.exp_reg;
          exp_val_d[bus.exp_idx] = bus.exp_val;
          vld_d[bus.exp_idx]     = 1'b1;
        end
        if (bus.start) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          cyc_d   = '0;
          fcnt_d  = '0;
          ffi_d   = '0;
          for (int i = 0; i < NREG; i++) shadow_d[i] = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (bus.wb_en && bus.wb_reg != '0)
          shadow_d[bus.wb_reg] = bus.wb_data;
        if (cyc_q == CW'(MAX_CYCLES - 1) || halt_w)
          state_d = S_CHECK;
      end
      S_CHECK: begin
        // entries are visited in ascending order, so the first hit is the lowest index
        if (vld_q[ci] && shadow_q[exp_reg_q[ci]] != exp_val_q[ci]) begin
          fcnt_d = fcnt_q + 1'b1;
          if (fcnt_q == '0) ffi_d = ci;
        end
        if (cnt_q == CNW'(NCHECK - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    core_reset_d = state_d inside {S_IDLE, S_HOLD};
    busy_d       = state_d inside {S_HOLD, S_RUN, S_CHECK};
    done_d       = state_d == S_DONE;
    pass_d       = done_d && fcnt_d == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cyc_q        <= '0;
      fcnt_q       <= '0;
      ffi_q        <= '0;
      vld_q        <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      fcnt_q       <= fcnt_d;
      ffi_q        <= ffi_d;
      vld_q        <= vld_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      shadow_q     <= shadow_d;
      exp_reg_q    <= exp_reg_d;
      exp_val_q    <= exp_val_d;
    end
  end

  assign bus.core_reset     = core_reset_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_cnt       = fcnt_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.cycle_cnt      = cyc_q;
endmodule
